// File: rtl/mux41_scan_ctrl.sv
// rtl/mux41_scan_ctrl.sv - scan sequencer for a 4:1 mux, assembles sampled bits into a frame
module mux41_scan_ctrl #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic [3:0] chan_mask,
  input  logic       y,
  output logic [1:0] s,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy
);

  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, SCAN, PRESENT} state_t;

  state_t        state, state_nxt;
  logic [1:0]    s_nxt;
  logic [3:0]    frame_nxt;
  logic [3:0]    mask, mask_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    first_ch, next_ch;
  logic          has_next;

  // first_ch comes from the live mask (scan entry); next_ch from the latched one
  always_comb begin
    first_ch = 2'b00;
    next_ch  = 2'b00;
    has_next = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (chan_mask[k]) first_ch = 2'(k);
      if (mask[k] && (k > int'(s))) begin
        next_ch  = 2'(k);
        has_next = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    frame_nxt = frame;
    cnt_nxt   = cnt;
    mask_nxt  = mask;
    case (state)
      IDLE: begin
        s_nxt = 2'b00;
        if (start && (chan_mask != 4'b0000)) begin
          state_nxt = SCAN;
          mask_nxt  = chan_mask;
          frame_nxt = 4'b0000;
          s_nxt     = first_ch;
          cnt_nxt   = '0;
        end
      end
      SCAN: begin
        if (cnt == LAST_CNT) begin
          frame_nxt[s] = y;
          cnt_nxt      = '0;
          if (has_next) s_nxt = next_ch;
          else          state_nxt = PRESENT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESENT: begin
        if (frame_ready) begin
          if (cont) mask_nxt = chan_mask;
          if (cont && (chan_mask != 4'b0000)) begin
            state_nxt = SCAN;
            frame_nxt = 4'b0000;
            s_nxt     = first_ch;
            cnt_nxt   = '0;
          end else begin
            state_nxt = IDLE;
            s_nxt     = 2'b00;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        s_nxt     = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      s     <= 2'b00;
      frame <= 4'b0000;
      cnt   <= '0;
      mask  <= 4'b0000;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      frame <= frame_nxt;
      cnt   <= cnt_nxt;
      mask  <= mask_nxt;
    end
  end

  assign frame_valid = (state == PRESENT);
  assign busy        = (state != IDLE);

endmodule
